mm_timer_irq: RTL and testbench

Memory-mapped machine-timer peripheral for the core testbench. It sits as a responder on the core data bus (req/gnt/rvalid protocol) next to the RAM, and owns a 64-bit prescaled time counter with a compare register. It drives the core's `irq_timer_i` line and consumes the core's `irq_ack_o`/`irq_id_o` to retire the interrupt.

---
 rtl/mm_timer_irq.sv | 148 ++++++++++++++
 tb/tb_mm_timer_irq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_timer_irq.sv
// Memory-mapped machine timer with 64-bit prescaled mtime/mtimecmp and sticky interrupt.
// Zero-wait-state grant; registered response one cycle after every grant, no backpressure.
module mm_timer_irq #(
    parameter logic [31:0] BASE_ADDR    = 32'h1500_0000,
    parameter int unsigned PRESCALE     = 1,
    parameter int unsigned TIMER_IRQ_ID = 7
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    input  logic        irq_ack_i,
    input  logic [4:0]  irq_id_i,
    output logic        irq_timer_o
);

    localparam logic [3:0]  OFF_MTIME_LO = 4'd0;
    localparam logic [3:0]  OFF_MTIME_HI = 4'd1;
    localparam logic [3:0]  OFF_CMP_LO   = 4'd2;
    localparam logic [3:0]  OFF_CMP_HI   = 4'd3;
    localparam logic [3:0]  OFF_CTRL     = 4'd4;
    localparam logic [3:0]  OFF_STATUS   = 4'd5;
    localparam logic [15:0] PRESC_MAX    = 16'(PRESCALE - 1);
    localparam logic [4:0]  IRQ_ID       = 5'(TIMER_IRQ_ID);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    logic [15:0] presc_q, presc_d;
    logic        en_q, en_d;
    logic        irq_en_q, irq_en_d;
    logic        pending_q, pending_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;

    logic        sel, wr, rd, tick, match, clr;
    logic [3:0]  off;
    logic [31:0] rmux;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^data_addr_i[1:0];

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    always_comb begin
        sel = data_req_i && (data_addr_i[31:6] == BASE_ADDR[31:6]);
        wr  = sel && data_we_i;
        rd  = sel && !data_we_i;
        off = data_addr_i[5:2];

        rmux = 32'd0;
        case (off)
            OFF_MTIME_LO: rmux = mtime_q[31:0];
            OFF_MTIME_HI: rmux = mtime_q[63:32];
            OFF_CMP_LO:   rmux = cmp_q[31:0];
            OFF_CMP_HI:   rmux = cmp_q[63:32];
            OFF_CTRL:     rmux = {30'd0, irq_en_q, en_q};
            OFF_STATUS:   rmux = {31'd0, pending_q};
            default:      rmux = 32'd0;
        endcase

        presc_d = presc_q;
        tick    = 1'b0;
        if (en_q) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = 16'd0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + 16'd1;
            end
        end

        // A software write to either half of mtime swallows this cycle's increment.
        mtime_d = mtime_q;
        if (wr && (off == OFF_MTIME_LO || off == OFF_MTIME_HI)) begin
            if (off == OFF_MTIME_LO) mtime_d[31:0]  = be_merge(mtime_q[31:0], data_wdata_i, data_be_i);
            if (off == OFF_MTIME_HI) mtime_d[63:32] = be_merge(mtime_q[63:32], data_wdata_i, data_be_i);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        cmp_d = cmp_q;
        if (wr && off == OFF_CMP_LO) cmp_d[31:0]  = be_merge(cmp_q[31:0], data_wdata_i, data_be_i);
        if (wr && off == OFF_CMP_HI) cmp_d[63:32] = be_merge(cmp_q[63:32], data_wdata_i, data_be_i);

        en_d     = en_q;
        irq_en_d = irq_en_q;
        if (wr && off == OFF_CTRL && data_be_i[0]) begin
            en_d     = data_wdata_i[0];
            irq_en_d = data_wdata_i[1];
        end

        // Set beats clear so a still-matching compare cannot be acknowledged away.
        match     = en_q && (mtime_q >= cmp_q);
        clr       = (wr && off == OFF_STATUS && data_be_i[0] && data_wdata_i[0]) ||
                    (irq_ack_i && irq_id_i == IRQ_ID);
        pending_d = match || (pending_q && !clr);
        irq_d     = pending_d && irq_en_d;

        rvalid_d = sel;
        rdata_d  = rd ? rmux : 32'd0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_q   <= 64'd0;
            cmp_q     <= {64{1'b1}};
            presc_q   <= 16'd0;
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            pending_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
            irq_q     <= 1'b0;
        end else begin
            mtime_q   <= mtime_d;
            cmp_q     <= cmp_d;
            presc_q   <= presc_d;
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            pending_q <= pending_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    assign data_gnt_o    = sel;
    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign irq_timer_o   = irq_q;

endmodule

// File: tb/tb_mm_timer_irq.sv
// Scoreboarded bench for mm_timer_irq: expected responses are queued at grant and retired on rvalid.
module tb_mm_timer_irq;

    localparam logic [31:0] BASE   = 32'h1500_0000;
    localparam logic [31:0] A_LO   = BASE + 32'h00;
    localparam logic [31:0] A_HI   = BASE + 32'h04;
    localparam logic [31:0] A_CLO  = BASE + 32'h08;
    localparam logic [31:0] A_CHI  = BASE + 32'h0C;
    localparam logic [31:0] A_CTRL = BASE + 32'h10;
    localparam logic [31:0] A_STAT = BASE + 32'h14;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [31:0] addr = 32'd0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic        gnt, rvalid, irq;
    logic [31:0] rdata;
    logic        ack = 1'b0;
    logic [4:0]  ack_id = 5'd0;

    logic        live_sel = 1'b0;
    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    mm_timer_irq #(
        .BASE_ADDR(BASE),
        .PRESCALE(1),
        .TIMER_IRQ_ID(7)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .data_req_i(req),
        .data_addr_i(addr),
        .data_we_i(we),
        .data_be_i(be),
        .data_wdata_i(wdata),
        .data_gnt_o(gnt),
        .data_rvalid_o(rvalid),
        .data_rdata_o(rdata),
        .irq_ack_i(ack),
        .irq_id_i(ack_id),
        .irq_timer_o(irq)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] wd, input logic [31:0] lo, input logic [31:0] hi);
        logic s;
        exp_t e;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; be = b; wdata = wd;
        s = (a[31:6] == BASE[31:6]);
        live_sel = s;
        #1 chk("gnt", gnt, s);
        if (s) begin
            e.lo = w ? 32'd0 : lo;
            e.hi = w ? 32'd0 : hi;
            sbq.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req = 1'b0; we = 1'b0; live_sel = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd);
        issue(1'b1, a, 4'hF, wd, 32'd0, 32'd0);
        idle();
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] lo, input logic [31:0] hi);
        issue(1'b0, a, 4'h0, 32'd0, lo, hi);
        idle();
    endtask

    task automatic pulse_ack(input logic [4:0] id);
        @(negedge clk);
        ack = 1'b1; ack_id = id;
        @(negedge clk);
        ack = 1'b0;
    endtask

    // Response monitor: rvalid must follow each grant by exactly one edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n) begin
                chk("rvalid", rvalid, live_sel);
                if (rvalid) begin
                    chk("sb_nonempty", sbq.size() > 0, 1);
                    if (sbq.size() > 0) begin
                        e = sbq.pop_front();
                        if (e.lo == e.hi) chk("rdata", rdata, e.lo);
                        else chk("rdata_in_range", (rdata >= e.lo) && (rdata <= e.hi), 1);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_irq", irq, 0);
        rst_n = 1'b1;
        rd(A_LO, 32'd0, 32'd0);
        rd(A_HI, 32'd0, 32'd0);
        rd(A_CLO, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(A_CHI, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(A_CTRL, 32'd0, 32'd0);
        rd(A_STAT, 32'd0, 32'd0);

        // Free-running count
        wr(A_CTRL, 32'd1);
        repeat (9) @(negedge clk);
        rd(A_LO, 32'd9, 32'd11);

        // Carry into the high word after two increments
        wr(A_CTRL, 32'd0);
        wr(A_LO, 32'hFFFF_FFFF);
        wr(A_HI, 32'd0);
        wr(A_CTRL, 32'd1);
        wr(A_CTRL, 32'd0);
        rd(A_HI, 32'd1, 32'd1);
        rd(A_LO, 32'd1, 32'd1);

        // Write coinciding with an increment edge holds the written value
        issue(1'b1, A_CTRL, 4'hF, 32'd1, 32'd0, 32'd0);
        issue(1'b1, A_LO, 4'hF, 32'h1234, 32'd0, 32'd0);
        issue(1'b0, A_LO, 4'h0, 32'd0, 32'h1234, 32'h1234);
        issue(1'b1, A_CTRL, 4'hF, 32'd0, 32'd0, 32'd0);
        idle();
        rd(A_HI, 32'd1, 32'd1);

        // Compare match raises the interrupt one edge after mtime reaches 20
        wr(A_LO, 32'd0);
        wr(A_HI, 32'd0);
        wr(A_CHI, 32'd0);
        wr(A_CLO, 32'd20);
        issue(1'b1, A_CTRL, 4'hF, 32'd3, 32'd0, 32'd0);
        idle();
        rise = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #2;
            if (irq && rise < 0) rise = k;
        end
        chk("irq_rise_edge", rise, 21);
        rd(A_STAT, 32'd1, 32'd1);

        // Ack while still matching: set wins
        pulse_ack(5'd7);
        chk("irq_ack_set_wins", irq, 1);
        rd(A_STAT, 32'd1, 32'd1);

        // Move compare away, then write-1-to-clear STATUS
        wr(A_CHI, 32'hFFFF_FFFF);
        chk("irq_sticky", irq, 1);
        issue(1'b1, A_STAT, 4'h1, 32'd1, 32'd0, 32'd0);
        chk("irq_before_w1c", irq, 1);
        idle();
        chk("irq_after_w1c", irq, 0);

        // Re-trigger, then clear via acknowledge
        wr(A_CHI, 32'd0);
        @(negedge clk);
        chk("irq_retrigger", irq, 1);
        wr(A_CHI, 32'hFFFF_FFFF);
        pulse_ack(5'd11);
        chk("irq_ack_wrong_id", irq, 1);
        pulse_ack(5'd7);
        chk("irq_ack_clear", irq, 0);
        rd(A_STAT, 32'd0, 32'd0);

        // Byte enables, unused bits, unmapped offsets, out-of-window requests
        wr(A_CLO, 32'hFFFF_FFFF);
        issue(1'b1, A_CLO, 4'b0010, 32'hAABB_CCDD, 32'd0, 32'd0);
        idle();
        rd(A_CLO, 32'hFFFF_CCFF, 32'hFFFF_CCFF);
        wr(A_CTRL, 32'hFFFF_FFFF);
        rd(A_CTRL, 32'd3, 32'd3);
        wr(BASE + 32'h1C, 32'hDEAD_BEEF);
        rd(BASE + 32'h18, 32'd0, 32'd0);
        issue(1'b0, BASE + 32'h40, 4'h0, 32'd0, 32'd0, 32'd0);
        idle();
        idle();

        // Back-to-back reads, then reset with a response outstanding
        issue(1'b0, A_CTRL, 4'h0, 32'd0, 32'd3, 32'd3);
        issue(1'b0, A_CLO, 4'h0, 32'd0, 32'hFFFF_CCFF, 32'hFFFF_CCFF);
        issue(1'b0, A_CHI, 4'h0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(1'b0, A_STAT, 4'h0, 32'd0, 32'd0, 32'd0);
        #1;
        chk("rvalid_before_rst", rvalid, 1);
        rst_n = 1'b0;
        req = 1'b0;
        live_sel = 1'b0;
        #1;
        chk("rst_async_rvalid", rvalid, 0);
        chk("rst_async_rdata", rdata, 0);
        chk("rst_async_irq", irq, 0);
        sbq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rvalid", rvalid, 0);
        chk("post_rst_rdata", rdata, 0);
        chk("post_rst_irq", irq, 0);
        rd(A_LO, 32'd0, 32'd0);
        rd(A_CHI, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(A_CTRL, 32'd0, 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
